// File: rtl/uart_rx_fifo.sv
// Memory-mapped 8N1 UART receiver with an RX FIFO and registered read data.
// Optional interrupt output rx_irq_o is built when UART_RX_IRQ_EN is defined.
module uart_rx_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0300,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_r_addr_i,
  input  logic [31:0] rx_w_addr_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_r_enable_i,
  input  logic        rx_w_enable_i,
  output logic [31:0] rx_data_o,
  input  logic        uart_rx
`ifdef UART_RX_IRQ_EN
  ,
  output logic        rx_irq_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Input synchroniser
  logic rx_meta_q;
  logic rxs_q;

  // Receiver
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;

  // Registers
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic [31:0] rx_data_q, rx_data_d;

  // FIFO
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          r_hit, w_hit;
  logic [1:0]    r_sel, w_sel;
  logic          fifo_empty, fifo_full;
  logic [PW-1:0] fifo_count;
  logic [31:0]   count_ext;
  logic [3:0]    count_sat;
  logic [7:0]    head;
  logic          pop, push, push_req, ferr_evt, ovr_evt;
  logic [15:0]   div_eff;
  logic          tick;
  logic [31:0]   rdata;

  logic unused_bits;
  assign unused_bits = ^{rx_r_addr_i[1:0], rx_w_addr_i[1:0], rx_data_i[31:16]};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign r_hit = rx_r_enable_i && (rx_r_addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_hit = rx_w_enable_i && (rx_w_addr_i[31:4] == BASE_ADDR[31:4]);
  assign r_sel = rx_r_addr_i[3:2];
  assign w_sel = rx_w_addr_i[3:2];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign count_ext  = 32'(fifo_count);
  assign count_sat  = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign pop     = r_hit && (r_sel == REG_DATA) && !fifo_empty;
  assign div_eff = (div_q < 16'd4) ? 16'd4 : div_q;
  assign tick    = (cnt_q == 16'd1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    ferr_evt  = 1'b0;

    if (state_q != S_IDLE && !tick) begin
      cnt_d = cnt_q - 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (en_q && !rxs_q) begin
          state_d = S_START;
          cnt_d   = div_eff >> 1;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxs_q) begin
            state_d   = S_DATA;
            cnt_d     = div_eff;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d   = {rxs_q, shift_q[7:1]};
          cnt_d     = div_eff;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          if (rxs_q) begin
            push_req = 1'b1;
          end else begin
            ferr_evt = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disabling the receiver abandons any partial frame.
    if (!en_q) begin
      state_d  = S_IDLE;
      push_req = 1'b0;
      ferr_evt = 1'b0;
    end
  end

  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign push    = push_req && (!fifo_full || pop);
  assign ovr_evt = push_req && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));
    en_d     = en_q;
    ie_d     = ie_q;
    div_d    = div_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;

    if (w_hit && w_sel == REG_CTRL) begin
      en_d = rx_data_i[0];
      ie_d = rx_data_i[1];
      if (rx_data_i[2]) begin
        ovr_d  = 1'b0;
        ferr_d = 1'b0;
      end
    end
    if (w_hit && w_sel == REG_DIV) begin
      div_d = rx_data_i[15:0];
    end
    if (ovr_evt) begin
      ovr_d = 1'b1;
    end
    if (ferr_evt) begin
      ferr_d = 1'b1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (r_sel)
      REG_DATA:   rdata = fifo_empty ? 32'd0 : {24'd0, head};
      REG_STATUS: rdata = {24'd0, count_sat, ferr_q, ovr_q, fifo_full, !fifo_empty};
      REG_CTRL:   rdata = {30'd0, ie_q, en_q};
      REG_DIV:    rdata = {16'd0, div_q};
      default:    rdata = 32'd0;
    endcase
    rx_data_d = r_hit ? rdata : rx_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      div_q     <= DIV_RESET;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rx_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      div_q     <= div_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rx_data_q <= rx_data_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  assign rx_data_o = rx_data_q;

`ifdef UART_RX_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = ie_q & (!fifo_empty | ovr_q | ferr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign rx_irq_o = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: register vector table plus serial frame sequences.
module tb_uart_rx_fifo;

  localparam logic [31:0] BASE     = 32'h0000_0300;
  localparam logic [31:0] A_DATA   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_CTRL   = BASE + 32'h8;
  localparam logic [31:0] A_DIV    = BASE + 32'hC;
  localparam int          BIT_CLKS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_r_addr_i;
  logic [31:0] rx_w_addr_i;
  logic [31:0] rx_data_i;
  logic        rx_r_enable_i;
  logic        rx_w_enable_i;
  logic [31:0] rx_data_o;
  logic        uart_rx;
`ifdef UART_RX_IRQ_EN
  logic        rx_irq_o;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .rx_r_addr_i   (rx_r_addr_i),
    .rx_w_addr_i   (rx_w_addr_i),
    .rx_data_i     (rx_data_i),
    .rx_r_enable_i (rx_r_enable_i),
    .rx_w_enable_i (rx_w_enable_i),
    .rx_data_o     (rx_data_o),
    .uart_rx       (uart_rx)
`ifdef UART_RX_IRQ_EN
    ,
    .rx_irq_o      (rx_irq_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] val;
    string       name;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    rx_r_addr_i   = addr;
    rx_r_enable_i = 1'b1;
    @(posedge clk);
    #1;
    rx_r_enable_i = 1'b0;
    @(negedge clk);
    data = rx_data_o;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    rx_w_addr_i   = addr;
    rx_data_i     = data;
    rx_w_enable_i = 1'b1;
    @(posedge clk);
    #1;
    rx_w_enable_i = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic idle_line(input int cycles);
    uart_rx = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] coll_data;

    vecs[0]  = '{1'b0, A_STATUS,     32'h0000_0000, "rst_status"};
    vecs[1]  = '{1'b0, A_DIV,        32'd434,       "rst_div"};
    vecs[2]  = '{1'b0, A_CTRL,       32'h0000_0000, "rst_ctrl"};
    vecs[3]  = '{1'b0, A_DATA,       32'h0000_0000, "empty_data"};
    vecs[4]  = '{1'b1, A_CTRL,       32'hFFFF_FFFF, "wr_ctrl_all"};
    vecs[5]  = '{1'b0, A_CTRL,       32'h0000_0003, "ctrl_readback"};
    vecs[6]  = '{1'b1, A_DIV,        32'h0001_0002, "wr_div_small"};
    vecs[7]  = '{1'b0, A_DIV,        32'h0000_0002, "div_unclamped_readback"};
    vecs[8]  = '{1'b0, 32'h0000_0400, 32'h0000_0002, "oob_read_holds"};
    vecs[9]  = '{1'b1, 32'h0000_0408, 32'h0000_0000, "oob_write"};
    vecs[10] = '{1'b0, A_CTRL,       32'h0000_0003, "oob_write_ignored"};
    vecs[11] = '{1'b1, A_CTRL,       32'h0000_0001, "wr_ctrl_en"};
    vecs[12] = '{1'b1, A_DIV,        32'd16,        "wr_div16"};
    vecs[13] = '{1'b0, A_CTRL,       32'h0000_0001, "ctrl_en"};
    vecs[14] = '{1'b0, A_DIV,        32'd16,        "div16"};

    rst           = 1'b1;
    uart_rx       = 1'b1;
    rx_r_addr_i   = 32'd0;
    rx_w_addr_i   = 32'd0;
    rx_data_i     = 32'd0;
    rx_r_enable_i = 1'b0;
    rx_w_enable_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data_o", rx_data_o, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].val);
      else read_check(vecs[i].name, vecs[i].addr, vecs[i].val);
    end

    // Single frame
    send_byte(8'hA5, 1'b1);
    read_check("a5_status", A_STATUS, 32'h11);
    read_check("a5_data", A_DATA, 32'h0000_00A5);
    read_check("a5_status_after", A_STATUS, 32'h00);

    // Overflow: nine frames into eight entries
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
    read_check("ovr_status", A_STATUS, 32'h87);
    for (int i = 1; i <= 8; i++) read_check($sformatf("ovr_data%0d", i), A_DATA, 32'(i));
    read_check("ovr_drained_status", A_STATUS, 32'h04);
    bus_write(A_CTRL, 32'h5);
    read_check("ovr_cleared", A_STATUS, 32'h00);
    read_check("ctrl_bit2_not_stored", A_CTRL, 32'h01);

    // Framing error, then a clean frame
    send_byte(8'h3C, 1'b0);
    idle_line(48);
    read_check("ferr_status", A_STATUS, 32'h08);
    bus_write(A_CTRL, 32'h5);
    read_check("ferr_cleared", A_STATUS, 32'h00);
    send_byte(8'h3C, 1'b1);
    read_check("after_ferr_status", A_STATUS, 32'h11);
    read_check("after_ferr_data", A_DATA, 32'h3C);

    // Short low glitch must not start a frame
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_line(48);
    read_check("glitch_status", A_STATUS, 32'h00);
    send_byte(8'h5A, 1'b1);
    read_check("post_glitch_data", A_DATA, 32'h5A);

    // Disable mid-frame discards the partial byte
    @(posedge clk);
    #1;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    bus_write(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b1);
    idle_line(32);
    read_check("abort_status", A_STATUS, 32'h00);
    read_check("abort_ctrl", A_CTRL, 32'h00);
    bus_write(A_CTRL, 32'h1);

    // Full FIFO: DATA read on the same edge as the STOP push
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
    read_check("fill_status", A_STATUS, 32'h83);
    coll_data = 32'hDEAD_BEEF;
    fork
      send_byte(8'h77, 1'b1);
      begin
        @(posedge clk);
        #1;
        repeat (9 * BIT_CLKS + 10) @(posedge clk);
        #1;
        rx_r_addr_i   = A_DATA;
        rx_r_enable_i = 1'b1;
        @(posedge clk);
        #1;
        rx_r_enable_i = 1'b0;
        @(negedge clk);
        coll_data = rx_data_o;
      end
    join
    check("coll_pop_data", coll_data, 32'h10);
    read_check("coll_status", A_STATUS, 32'h83);
    for (int i = 1; i < 8; i++) read_check($sformatf("coll_data%0d", i), A_DATA, 32'h10 + 32'(i));
    read_check("coll_last", A_DATA, 32'h77);
    read_check("coll_empty", A_STATUS, 32'h00);

    // Reset mid-frame
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst     = 1'b1;
    uart_rx = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rx_data_o", rx_data_o, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    read_check("midrst_div", A_DIV, 32'd434);
    read_check("midrst_ctrl", A_CTRL, 32'h0);
    read_check("midrst_status", A_STATUS, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
